// File: rtl/fb_arb_pkg.sv
// Shared types and address helper for the VGA frame-buffer arbiter.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        WRITE = 2'd0,
        HOLD  = 2'd1,
        SKIP  = 2'd2
    } cam_state_t;

    localparam int unsigned NUM_CAM   = 2;
    localparam int unsigned PAGE_BITS = 1;
    localparam int unsigned CAM_BITS  = 1;
    localparam int unsigned MAX_OFF_W = 32;
    localparam int unsigned FB_W      = MAX_OFF_W + PAGE_BITS + CAM_BITS;

    // Builds {cam, page, offset} with the offset field off_w bits wide.
    function automatic logic [FB_W-1:0] fb_addr(
        input logic                 cam,
        input logic                 page,
        input logic [MAX_OFF_W-1:0] offset,
        input int unsigned          off_w
    );
        logic [FB_W-1:0] hi;
        hi = FB_W'({cam, page}) << off_w;
        return hi | FB_W'(offset);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Camera, display-read and memory signal bundle for the frame-buffer arbiter.
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 16
);
    logic                  frame_tick;
    logic                  rd_req;
    logic                  rd_cam;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic [1:0]            cam_valid;
    logic [1:0]            cam_ready;
    logic [2*ADDR_W-1:0]   cam_addr;
    logic [2*DATA_W-1:0]   cam_data;
    logic [1:0]            cam_sof;
    logic [1:0]            cam_eof;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W+1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic [1:0]            front_page;

    modport slave (
        input  frame_tick, rd_req, rd_cam, rd_addr,
        input  cam_valid, cam_addr, cam_data, cam_sof, cam_eof,
        input  mem_rdata,
        output rd_data, rd_valid, cam_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, front_page
    );

    modport master (
        output frame_tick, rd_req, rd_cam, rd_addr,
        output cam_valid, cam_addr, cam_data, cam_sof, cam_eof,
        output mem_rdata,
        input  rd_data, rd_valid, cam_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, front_page
    );
endinterface

// File: rtl/cam_page_ctrl.sv
// Per-camera double-buffer page FSM: tracks the displayed page and decides
// whether the current beat needs memory (wr_req) or is thrown away (drop).
module cam_page_ctrl
    import fb_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_sof,
    input  logic i_eof,
    input  logic i_grant,
    input  logic i_frame_tick,
    output logic o_wr_req,
    output logic o_drop,
    output logic o_back_page,
    output logic o_front
);

    cam_state_t r_state;
    cam_state_t w_state_nxt;
    logic       r_front;
    logic       w_front_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WRITE;
            r_front <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_front <= w_front_nxt;
        end
    end

    // A tick only matters in HOLD, so an eof landing with a tick waits for the next one.
    always_comb begin
        w_state_nxt = r_state;
        w_front_nxt = r_front;
        o_wr_req    = 1'b0;
        o_drop      = 1'b0;
        case (r_state)
            WRITE: begin
                o_wr_req = i_valid;
                if (i_grant && i_eof) w_state_nxt = HOLD;
            end
            HOLD: begin
                o_drop = i_valid;
                if (i_frame_tick) begin
                    w_front_nxt = ~r_front;
                    w_state_nxt = SKIP;
                end
            end
            SKIP: begin
                if (i_valid && i_sof) begin
                    o_wr_req = 1'b1;
                    if (i_grant) w_state_nxt = i_eof ? HOLD : WRITE;
                end else begin
                    o_drop = i_valid;
                end
            end
            default: w_state_nxt = WRITE;
        endcase
    end

    assign o_front     = r_front;
    assign o_back_page = ~r_front;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads first, camera writes
// round-robin, with tear-free page swaps at vertical blank.
module vga_fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    vga_fb_arbiter_if.slave  bus
);

    localparam int unsigned MA_W = ADDR_W + 2;

    logic [1:0] w_wr_req;
    logic [1:0] w_drop;
    logic [1:0] w_back;
    logic [1:0] w_front;
    logic [1:0] w_grant;
    logic       r_last_cam;
    logic       r_rd_valid;

    cam_page_ctrl u_cam0 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (bus.cam_valid[0]),
        .i_sof        (bus.cam_sof[0]),
        .i_eof        (bus.cam_eof[0]),
        .i_grant      (w_grant[0]),
        .i_frame_tick (bus.frame_tick),
        .o_wr_req     (w_wr_req[0]),
        .o_drop       (w_drop[0]),
        .o_back_page  (w_back[0]),
        .o_front      (w_front[0])
    );

    cam_page_ctrl u_cam1 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (bus.cam_valid[1]),
        .i_sof        (bus.cam_sof[1]),
        .i_eof        (bus.cam_eof[1]),
        .i_grant      (w_grant[1]),
        .i_frame_tick (bus.frame_tick),
        .o_wr_req     (w_wr_req[1]),
        .o_drop       (w_drop[1]),
        .o_back_page  (w_back[1]),
        .o_front      (w_front[1])
    );

    // r_last_cam=1 means cam1 was granted last, so cam0 wins the next tie.
    always_comb begin
        w_grant = 2'b00;
        if (!bus.rd_req) begin
            case (w_wr_req)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_cam ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_cam <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_grant != 2'b00) r_last_cam <= w_grant[1];
            r_rd_valid <= bus.rd_req;
        end
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.rd_req) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = MA_W'(fb_addr(bus.rd_cam, w_front[bus.rd_cam],
                                         MAX_OFF_W'(bus.rd_addr), ADDR_W));
        end else if (w_grant[0]) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = MA_W'(fb_addr(1'b0, w_back[0],
                                          MAX_OFF_W'(bus.cam_addr[ADDR_W-1:0]), ADDR_W));
            bus.mem_wdata = bus.cam_data[DATA_W-1:0];
        end else if (w_grant[1]) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = MA_W'(fb_addr(1'b1, w_back[1],
                                          MAX_OFF_W'(bus.cam_addr[2*ADDR_W-1:ADDR_W]), ADDR_W));
            bus.mem_wdata = bus.cam_data[2*DATA_W-1:DATA_W];
        end
    end

    assign bus.cam_ready  = w_grant | w_drop;
    assign bus.front_page = w_front;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = r_rd_valid ? bus.mem_rdata : '0;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port frame-buffer arbiter and page scheduler between two camera write streams and the VGA display read path. Runs on the system clock `clk`, same domain as the pixel strobe generator. Display reads always win, and camera writes share the remaining cycles round-robin. Each camera is double-buffered, and the finished back page is swapped to front only at the display's vertical-blank tick, so the displayed image never tears.

## Interface
- `ADDR_W`, default 17: pixel offset width within one page (320×240 = 76800 words).
- `DATA_W`, default 16: pixel width (RGB565).
- `clk`  in  1  system clock (4× pixel rate).
- `reset`  in  1  asynchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse at the start of display vertical blank.
- `rd_req`  in  1  display read request, one cycle per pixel, at most 1 per 4 clk.
- `rd_cam`  in  1  camera whose front page is displayed.
- `rd_addr`  in  ADDR_W  pixel offset.
- `rd_data`  out  DATA_W  read pixel.
- `rd_valid`  out  1  `rd_data` valid.
- `cam_valid`  in  2  per-camera write beat valid.
- `cam_ready`  out  2  per-camera beat accepted.
- `cam_addr`  in  2×ADDR_W  write offsets, cam0 in the LSBs.
- `cam_data`  in  2×DATA_W  write pixels, cam0 in the LSBs.
- `cam_sof`  in  2  beat is the first pixel of a frame.
- `cam_eof`  in  2  beat is the last pixel of a frame.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  write (1) or read (0).
- `mem_addr`  out  ADDR_W+2  memory address, laid out as {cam, page, offset}.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data, 1-cycle latency.
- `front_page`  out  2  displayed page per camera.

## Operation
- **Per-camera page FSM, states WRITE / HOLD / SKIP.**
  - WRITE: each accepted beat writes {cam, ~front, offset}. An accepted beat with eof moves to HOLD.
  - HOLD: back page complete. Beats are accepted and discarded (ready=1, no memory access). On `frame_tick`, toggle front, then go to SKIP.
  - SKIP: non-sof beats are accepted and discarded. A sof beat needs memory and competes as a write. When granted, it is written and the FSM goes to WRITE, or to HOLD if eof is also set.
  - In WRITE, a sof beat is an ordinary write (frame restart); there is no state change.
- **Arbitration, per cycle.**
  - `rd_req` wins: `mem_en`=1, `mem_we`=0, `mem_addr`={rd_cam, front_page[rd_cam], rd_addr}.
  - Otherwise the write-requesting cameras are arbitrated round-robin. On contention, the camera not granted most recently wins. The pointer updates on every write grant.
  - `cam_ready` for a write beat equals its grant. It is combinational from `cam_valid`/`rd_req` and may depend on valid.
  - Discard beats never touch memory and are never blocked.
- Read addresses use front_page as registered before any same-cycle `frame_tick` flip.

## Timing
- Reset values: front_page=00, both FSMs in WRITE, round-robin pointer = cam1 last (cam0 wins first contention), `rd_valid`=0, `rd_data`=0.
- `mem_*` and `cam_ready` are combinational; with all inputs idle, `mem_en`=`mem_we`=0.
- Read latency: request in cycle t → `rd_valid`=1 in t+1 with `rd_data`=`mem_rdata` (registered valid, data passed through).
- A write is committed in the grant cycle.
- Simultaneous eof beat and `frame_tick`: the beat is written and the FSM goes to HOLD, but no swap happens on that tick; the flip waits for the next tick.
- A `frame_tick` in WRITE or SKIP does nothing.
- A sof beat in HOLD is discarded and the FSM stays in HOLD.
- Reset mid-frame returns everything to the reset values immediately. A pending `rd_valid` is cleared.
- Write throughput is at least 3 beats per 4 clk when reads run at the pixel rate.

## Structure
- `fb_arb_pkg` contains:
  - `cam_state_t` enum {WRITE, HOLD, SKIP};
  - `NUM_CAM`=2, `PAGE_BITS`=1;
  - function `fb_addr(cam, page, offset)`.
- Sub-module `cam_page_ctrl`, one per camera. It holds the FSM and the front bit, and outputs `wr_req`, `drop`, and the back page. The top level holds arbitration, the round-robin pointer and the read pipeline.

## Test plan
- Reset, then cam0 streams 4 beats (sof at offset 0, eof at offset 3, data 0xA000+i) → mem writes to {0,1,0..3}, cam0 FSM in HOLD, front_page=00.
- `frame_tick` after the above → front_page=01. A cam0 non-sof beat is discarded with ready=1. `rd_req` cam0 offset 2 → `mem_addr`={0,1,2}; `rd_valid` next cycle with 0xA002.
- Both cameras valid every cycle, no reads → grants alternate cam0, cam1, cam0… A `rd_req` every 4th cycle blocks both cameras in that cycle only.
- An eof beat on cam1 in the same cycle as `frame_tick` → the write lands in page 1, the FSM enters HOLD, front_page[1] stays 0 until the next tick.
- A SKIP-state cam0 sof beat competes with a WRITE-state cam1 beat → both are written in consecutive cycles per the round-robin order, and cam0 returns to WRITE.
- Assert reset while cam1 is in HOLD and a read is in flight → `rd_valid`=0, front_page=00, both FSMs in WRITE.
